life_array_ctrl: RTL
====================

// Module: life_array_ctrl
// PURPOSE
//  Command-driven master for a 16-cell life tile (4 columns x 4 cells, bit i = col i/4, row i%4).
//  Drives the tile's val/write_enb/step inputs and samples its alive vector.
//  Accepts LOAD / STEP-N / READ commands over a valid/ready port; returns tile state on a valid/ready response port.
//  Sits between the host/scan logic and the tile. Owns all generation timing.
// PARAMETERS
//  GEN_W      16  width of step count and generation counter
//  STEP_HIGH  2   cycles step held high per generation (>=1)
//  STEP_LOW   2   cycles step held low after each high phase (>=2; lets tile finish update)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  reset      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept command
//  cmd_op     in   2      00 NOP, 01 LOAD, 10 STEP, 11 READ
//  cmd_data   in   16     LOAD: pattern; STEP: count in [GEN_W-1:0]; else ignored
//  rsp_valid  out  1      response holds tile state
//  rsp_ready  in   1      host takes response
//  rsp_data   out  16     captured alive vector
//  val        out  16     pattern to tile
//  write_enb  out  1      tile write strobe
//  step       out  1      tile generation request (tile advances once per rising edge)
//  alive      in   16     tile cell states
//  busy       out  1      FSM not in IDLE
//  gen_count  out  GEN_W  generations issued since last LOAD; wraps at 2^GEN_W
//  stable     out  1      tile stopped changing (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0; FSM=IDLE; remaining count 0. Deassertion synchronous to clk.
//  All outputs registered. Handshake fires when valid & ready on a posedge.
//  cmd_ready = (state==IDLE) & ~rsp_valid. Command is captured on handshake. No command accepted while busy.
//  FSM states: IDLE, LOAD, STEP_HI, STEP_LO, RESP.
//  NOP: accepted; no state change; no output change.
//  LOAD: next cycle val=cmd_data, write_enb=1 for exactly 1 cycle (state LOAD).
//   gen_count<=0; stable<=0; then IDLE. val holds last pattern afterwards.
//  STEP N, N=0: accepted; FSM stays IDLE; no step pulse.
//  STEP N, N>0: STEP_HI: step=1 for STEP_HIGH cycles; then STEP_LO: step=0 for STEP_LOW cycles.
//   gen_count+1 on entering STEP_LO.
//   Remaining-1 at end of STEP_LO. Re-enter STEP_HI if remaining!=0, else IDLE.
//   Total N*(STEP_HIGH+STEP_LOW) cycles. step never high 2 generations back-to-back without the low gap.
//  READ: next cycle alive sampled into rsp_data; rsp_valid=1 (state RESP).
//   Held stable until rsp_ready. Handshake clears rsp_valid, FSM to IDLE the same edge.
//   cmd_ready rises the following cycle.
//  rsp_ready while rsp_valid=0: ignored.
//  gen_count overflow wraps to 0 silently. stable is not reset by STEP.
//  Reset mid-STEP: step drops to 0 asynchronously. Remaining count is lost.
//  Reset mid-RESP: response is dropped.
//  cmd_op/cmd_data may change freely when cmd_ready=0.
// CONFIGURATION
//  LIFE_CTRL_STABLE_STOP_EN defined:
//   - Snapshot alive on entering STEP_HI.
//   - On the last cycle of STEP_LO, compare alive to the snapshot.
//   - If equal: stable<=1, remaining<=0, FSM to IDLE (STEP aborted early).
//   - gen_count still counts that generation.
//  LIFE_CTRL_STABLE_STOP_EN undefined:
//   - No snapshot register. stable tied 0. STEP always runs all N generations.
// TESTING
//  T1 reset=0 mid STEP_HI -> step=0, busy=0, gen_count=0 immediately. First cmd_ready=1 one cycle after reset=1.
//  T2 LOAD 16'h0660 (block) -> one write_enb pulse, val=16'h0660. Then READ -> rsp_data=16'h0660; stall rsp_ready 5 cycles -> data held.
//  T3 LOAD 16'h0070 (blinker), STEP 1, READ -> rsp_data=16'h0222. STEP 1, READ -> 16'h0070. gen_count=2. Step high exactly STEP_HIGH cycles per generation.
//  T4 STEP 0 -> no step pulse, gen_count unchanged. NOP -> no effect. cmd_valid held during STEP 3 -> only first accepted, cmd_ready low 12 cycles (defaults).
//  T5 GEN_W=4, STEP 17 after LOAD -> gen_count=1 (wrap).
//  T6 (STABLE_STOP_EN) LOAD 16'h0660, STEP 10 -> stable=1, gen_count=1, busy low after 4 cycles. Without macro -> gen_count=10, stable=0.

Source files
------------

// File: rtl/life_array_ctrl.sv
// life_array_ctrl: command-driven master for a 16-cell (4x4) life tile.
// Accepts LOAD / STEP-N / READ commands over a valid/ready port. It drives
// the tile's val/write_enb/step inputs and returns sampled alive vectors on a
// valid/ready response port. All outputs are registered.
// Optional feature macro: LIFE_CTRL_STABLE_STOP_EN. When it is defined, a STEP
// aborts early once a generation leaves the tile unchanged, and stable is set.
module life_array_ctrl #(
    parameter int unsigned GEN_W     = 16,
    parameter int unsigned STEP_HIGH = 2,
    parameter int unsigned STEP_LOW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [15:0]      cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [15:0]      val,
    output logic             write_enb,
    output logic             step,
    input  logic [15:0]      alive,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable
);

    localparam int unsigned PH_MAX = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] PH_HI_END = PH_W'(STEP_HIGH - 1);
    localparam logic [PH_W-1:0] PH_LO_END = PH_W'(STEP_LOW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP_HI,
        S_STEP_LO,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_STEP = 2'b10,
        OP_READ = 2'b11
    } op_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PH_W-1:0]    r_phase;
    logic [PH_W-1:0]    w_phase_nxt;
    logic [GEN_W-1:0]   r_remaining;
    logic [GEN_W-1:0]   w_remaining_nxt;
    logic [GEN_W-1:0]   w_rem_dec;
    logic [GEN_W-1:0]   w_step_count;
    logic [GEN_W-1:0]   r_gen;
    logic [GEN_W-1:0]   w_gen_nxt;
    logic [15:0]        r_val;
    logic [15:0]        w_val_nxt;
    logic [15:0]        r_rsp_data;
    logic [15:0]        w_rsp_data_nxt;

    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic               r_write_enb;
    logic               r_step;
    logic               r_busy;
    logic               w_cmd_ready_nxt;
    logic               w_rsp_valid_nxt;
    logic               w_write_enb_nxt;
    logic               w_step_nxt;
    logic               w_busy_nxt;

    op_t                w_op;
    logic               w_cmd_fire;
    logic               w_rsp_fire;
    logic               w_lo_last;
    logic               w_same;

    assign w_op         = op_t'(cmd_op);
    assign w_cmd_fire   = cmd_valid & r_cmd_ready;
    assign w_rsp_fire   = r_rsp_valid & rsp_ready;
    assign w_step_count = GEN_W'(cmd_data);
    assign w_rem_dec    = r_remaining - 1'b1;
    assign w_lo_last    = (r_state == S_STEP_LO) && (r_phase == PH_LO_END);

`ifdef LIFE_CTRL_STABLE_STOP_EN
    logic [15:0] r_snap;
    logic        r_stable;
    logic        w_load_fire;

    assign w_load_fire = w_cmd_fire && (w_op == OP_LOAD);
    assign w_same      = (alive == r_snap);
    assign stable      = r_stable;

    // Snapshot the tile at each generation start; track the stable flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap   <= '0;
            r_stable <= 1'b0;
        end else begin
            if ((w_state_nxt == S_STEP_HI) && (r_state != S_STEP_HI))
                r_snap <= alive;
            if (w_load_fire)
                r_stable <= 1'b0;
            else if (w_lo_last && w_same)
                r_stable <= 1'b1;
        end
    end
`else
    assign w_same = 1'b0;
    assign stable = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_remaining <= '0;
            r_gen       <= '0;
            r_val       <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_remaining <= w_remaining_nxt;
            r_gen       <= w_gen_nxt;
            r_val       <= w_val_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_remaining_nxt = r_remaining;
        w_gen_nxt       = r_gen;
        w_val_nxt       = r_val;
        w_rsp_data_nxt  = r_rsp_data;
        unique case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    case (w_op)
                        OP_LOAD: begin
                            w_state_nxt = S_LOAD;
                            w_val_nxt   = cmd_data;
                            w_gen_nxt   = '0;
                        end
                        OP_STEP: begin
                            if (w_step_count != '0) begin
                                w_state_nxt     = S_STEP_HI;
                                w_remaining_nxt = w_step_count;
                                w_phase_nxt     = '0;
                            end
                        end
                        OP_READ: begin
                            w_state_nxt    = S_RESP;
                            w_rsp_data_nxt = alive;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_LOAD: begin
                w_state_nxt = S_IDLE;
            end
            S_STEP_HI: begin
                if (r_phase == PH_HI_END) begin
                    w_state_nxt = S_STEP_LO;
                    w_phase_nxt = '0;
                    w_gen_nxt   = r_gen + 1'b1;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            S_STEP_LO: begin
                if (w_lo_last) begin
                    w_phase_nxt = '0;
                    // A generation that left the tile unchanged ends the run
                    if (w_same) begin
                        w_remaining_nxt = '0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_remaining_nxt = w_rem_dec;
                        w_state_nxt     = (w_rem_dec != '0) ? S_STEP_HI : S_IDLE;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            S_RESP: begin
                if (w_rsp_fire)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs track the state
    always_comb begin
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && !w_rsp_valid_nxt;
        w_write_enb_nxt = (w_state_nxt == S_LOAD);
        w_step_nxt      = (w_state_nxt == S_STEP_HI);
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_write_enb <= 1'b0;
            r_step      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_write_enb <= w_write_enb_nxt;
            r_step      <= w_step_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign val       = r_val;
    assign write_enb = r_write_enb;
    assign step      = r_step;
    assign busy      = r_busy;
    assign gen_count = r_gen;

endmodule
